// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA datapath blocks.
//   state_t  : control states of the serial adder (IDLE / RUN / DONE)
//   width_ok : elaboration-time legality check for WIDTH / DIGIT pairs
// ---------------------------------------------------------------------------
package ula_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A legal configuration splits the operand into a whole number of digits.
  function automatic bit width_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/soma_serial_param_if.sv
// ---------------------------------------------------------------------------
// soma_serial_param_if
// Handshake/operand bus between the ULA controller and the serial adder.
//   start    : request, honoured only when the adder is not computing
//   a, b     : operands (WIDTH bits)
//   c_in     : carry-in
//   sub      : 0 = add b, 1 = add ~b
//   busy     : adder is computing
//   done     : one-cycle pulse, result valid
//   result   : WIDTH+1 bit sum, MSB is the final carry-out
//   overflow : signed overflow of the WIDTH-bit sum
// modport master : controller side; modport slave : adder side
// ---------------------------------------------------------------------------
interface soma_serial_param_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;
  logic             overflow;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, result, overflow
  );

endinterface

// File: rtl/soma_digito.sv
// ---------------------------------------------------------------------------
// full_adder / soma_digito
// full_adder  : one-bit full adder (a, b, ci -> s, co).
// soma_digito : combinational DIGIT-bit ripple adder built from full_adder.
//   x, y   : digit operands
//   cin    : carry into bit 0
//   s      : digit sum
//   cout   : carry out of the MSB
//   c_last : carry into the MSB, paired with cout for signed overflow
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module soma_digito #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_last
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = cin;

  for (genvar g = 0; g < DIGIT; g++) begin : g_bit
    full_adder u_fa (
      .a  (x[g]),
      .b  (y[g]),
      .ci (w_c[g]),
      .s  (s[g]),
      .co (w_c[g+1])
    );
  end

  assign cout   = w_c[DIGIT];
  assign c_last = w_c[DIGIT-1];

endmodule

// File: rtl/soma_serial_param.sv
// ---------------------------------------------------------------------------
// soma_serial_param
// Multi-cycle adder/subtractor: result = a + (sub ? ~b : b) + c_in, computed
// DIGIT bits per clock over NUM_DIGITS = WIDTH/DIGIT cycles through a single
// shared soma_digito.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   s_bus : soma_serial_param_if.slave (start/a/b/c_in/sub in,
//           busy/done/result/overflow out)
// A start is accepted in IDLE or DONE (DONE -> RUN without an IDLE gap);
// start during RUN is ignored. result/overflow hold until the next accepted
// start or reset.
// ---------------------------------------------------------------------------
module soma_serial_param
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  soma_serial_param_if.slave s_bus
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("soma_serial_param: WIDTH (%0d) must be a multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH:0]   r_result;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_clast;

  // Current digit slice of the registered operands.
  assign w_x = r_a[r_idx*DIGIT +: DIGIT];
  assign w_y = r_bx[r_idx*DIGIT +: DIGIT];

  soma_digito #(
    .DIGIT (DIGIT)
  ) u_digito (
    .x      (w_x),
    .y      (w_y),
    .cin    (r_carry),
    .s      (w_s),
    .cout   (w_cout),
    .c_last (w_clast)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_bx       <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (s_bus.start) begin
            // b is inverted once at capture, so RUN only ever adds.
            r_a        <= s_bus.a;
            r_bx       <= s_bus.sub ? ~s_bus.b : s_bus.b;
            r_carry    <= s_bus.c_in;
            r_idx      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_result[r_idx*DIGIT +: DIGIT] <= w_s;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            // Last digit: carry into the MSB vs. carry out of it gives the
            // signed overflow of the full WIDTH-bit sum.
            r_result[WIDTH] <= w_cout;
            r_overflow      <= w_clast ^ w_cout;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_state         <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_bus.busy     = r_busy;
  assign s_bus.done     = r_done;
  assign s_bus.result   = r_result;
  assign s_bus.overflow = r_overflow;

endmodule
